// File: rtl/connect4_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : connect4_game_ctrl
// Purpose  : Connect-4 game controller: column select, token drop, win/draw
//            detection and game restart on a 6x7 board.
// Revision : 1.0 - initial release
// ============================================================================
module connect4_game_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 left,
    input  logic                 right,
    input  logic                 put,
    output logic [5:0][6:0][1:0] panel,
    output logic [6:0]           play,
    output logic                 player,
    output logic [1:0]           winner
);

    localparam logic [6:0] c_PLAY_INIT   = 7'b0001000;
    localparam logic [5:0] c_MAX_TOKENS  = 6'd42;
    localparam logic [1:0] c_IN_PROGRESS = 2'b00;
    localparam logic [1:0] c_DRAW        = 2'b11;
    localparam logic [1:0] c_EMPTY       = 2'b00;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_left_q;
    logic                 r_right_q;
    logic                 r_put_q;
    logic                 r_armed;
    logic                 w_left_ev;
    logic                 w_right_ev;
    logic                 w_put_ev;

    logic [5:0][6:0][1:0] r_panel;
    logic [5:0][6:0][1:0] w_panel_nxt;
    logic [6:0]           r_play;
    logic [6:0]           w_play_nxt;
    logic                 r_player;
    logic                 w_player_nxt;
    logic [1:0]           r_winner;
    logic [1:0]           w_winner_nxt;
    logic [5:0]           r_count;
    logic [5:0]           w_count_nxt;

    logic [2:0]           w_col;
    logic [2:0]           w_drop_row;
    logic                 w_col_full;
    logic [1:0]           w_code;
    logic                 w_win;

    // r_armed blocks the first edge after reset so a held button is not a press
    assign w_left_ev  = r_armed & left  & ~r_left_q;
    assign w_right_ev = r_armed & right & ~r_right_q;
    assign w_put_ev   = r_armed & put   & ~r_put_q;

    assign w_code = {r_player, ~r_player};

    always_comb begin : p_col_sel
        w_col = 3'd0;
        for (int j = 0; j < 7; j++) begin
            if (r_play[j]) begin
                w_col = 3'(j);
            end
        end
    end

    // Descending scan: the last hit is the lowest empty row
    always_comb begin : p_drop_row
        w_drop_row = 3'd0;
        for (int r = 5; r >= 0; r--) begin
            if (r_panel[r][w_col] == c_EMPTY) begin
                w_drop_row = 3'(r);
            end
        end
    end

    assign w_col_full = (r_panel[5][w_col] != c_EMPTY);

    always_comb begin : p_win
        w_win = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r_panel[r][c]   == w_code && r_panel[r][c+1] == w_code &&
                    r_panel[r][c+2] == w_code && r_panel[r][c+3] == w_code) begin
                    w_win = 1'b1;
                end
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 7; c++) begin
                if (r_panel[r][c]   == w_code && r_panel[r+1][c] == w_code &&
                    r_panel[r+2][c] == w_code && r_panel[r+3][c] == w_code) begin
                    w_win = 1'b1;
                end
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r_panel[r][c]     == w_code && r_panel[r+1][c+1] == w_code &&
                    r_panel[r+2][c+2] == w_code && r_panel[r+3][c+3] == w_code) begin
                    w_win = 1'b1;
                end
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 3; c < 7; c++) begin
                if (r_panel[r][c]     == w_code && r_panel[r+1][c-1] == w_code &&
                    r_panel[r+2][c-2] == w_code && r_panel[r+3][c-3] == w_code) begin
                    w_win = 1'b1;
                end
            end
        end
    end

    always_comb begin : p_next
        w_state_nxt  = r_state;
        w_panel_nxt  = r_panel;
        w_play_nxt   = r_play;
        w_player_nxt = r_player;
        w_winner_nxt = r_winner;
        w_count_nxt  = r_count;
        case (r_state)
            ST_PLAY: begin
                // A put swallows any same-cycle move, even when the column is full
                if (w_put_ev) begin
                    if (!w_col_full) begin
                        w_panel_nxt[w_drop_row][w_col] = w_code;
                        if (r_count != c_MAX_TOKENS) begin
                            w_count_nxt = r_count + 6'd1;
                        end
                        w_state_nxt = ST_CHECK;
                    end
                end else if (w_left_ev && !w_right_ev) begin
                    w_play_nxt = {r_play[0], r_play[6:1]};
                end else if (w_right_ev && !w_left_ev) begin
                    w_play_nxt = {r_play[5:0], r_play[6]};
                end
            end
            ST_CHECK: begin
                if (w_win) begin
                    w_winner_nxt = w_code;
                    w_state_nxt  = ST_OVER;
                end else if (r_count == c_MAX_TOKENS) begin
                    w_winner_nxt = c_DRAW;
                    w_state_nxt  = ST_OVER;
                end else begin
                    w_player_nxt = ~r_player;
                    w_state_nxt  = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (w_put_ev) begin
                    w_panel_nxt  = '0;
                    w_play_nxt   = c_PLAY_INIT;
                    w_player_nxt = 1'b0;
                    w_winner_nxt = c_IN_PROGRESS;
                    w_count_nxt  = 6'd0;
                    w_state_nxt  = ST_PLAY;
                end
            end
            default: begin
                w_state_nxt = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin : p_state
        if (!rst) begin
            r_state <= ST_PLAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin : p_regs
        if (!rst) begin
            r_panel   <= '0;
            r_play    <= c_PLAY_INIT;
            r_player  <= 1'b0;
            r_winner  <= c_IN_PROGRESS;
            r_count   <= 6'd0;
            r_left_q  <= 1'b0;
            r_right_q <= 1'b0;
            r_put_q   <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_panel   <= w_panel_nxt;
            r_play    <= w_play_nxt;
            r_player  <= w_player_nxt;
            r_winner  <= w_winner_nxt;
            r_count   <= w_count_nxt;
            r_left_q  <= left;
            r_right_q <= right;
            r_put_q   <= put;
            r_armed   <= 1'b1;
        end
    end

    assign panel  = r_panel;
    assign play   = r_play;
    assign player = r_player;
    assign winner = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_connect4_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_connect4_game_ctrl
// Purpose  : Scoreboard bench for connect4_game_ctrl against a board model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_connect4_game_ctrl;

    logic                 clk;
    logic                 rst;
    logic                 left;
    logic                 right;
    logic                 put;
    logic [5:0][6:0][1:0] panel;
    logic [6:0]           play;
    logic                 player;
    logic [1:0]           winner;

    connect4_game_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .left   (left),
        .right  (right),
        .put    (put),
        .panel  (panel),
        .play   (play),
        .player (player),
        .winner (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0][6:0][1:0] panel;
        logic [6:0]           play;
        logic                 player;
        logic [1:0]           winner;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // Board model: 0 empty, 1 player 0, 2 player 1; columns as plain integers
    int m_board[6][7];
    int m_col;
    int m_player;
    int m_winner;
    int m_tokens;
    bit m_check;
    bit m_over;
    bit m_pl;
    bit m_pr;
    bit m_pp;

    int draw_seq[42] = '{0, 0, 0, 0, 0, 0,
                         1, 2, 2, 1, 1, 2, 2, 1, 1, 2, 2, 1,
                         4, 3, 3, 4, 4, 3, 3, 4, 4, 3, 3, 4,
                         5, 6, 6, 5, 5, 6, 6, 5, 5, 6, 6, 5};

    function automatic bit has_win(input int code);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 7; c++) begin
                for (int d = 0; d < 4; d++) begin
                    int er = r + 3 * dr[d];
                    int ec = c + 3 * dc[d];
                    if (er < 6 && ec >= 0 && ec < 7) begin
                        bit same = 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            if (m_board[r + k * dr[d]][c + k * dc[d]] != code) same = 1'b0;
                        end
                        if (same) return 1'b1;
                    end
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic model_new_game();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 7; c++) m_board[r][c] = 0;
        end
        m_col    = 3;
        m_player = 0;
        m_winner = 0;
        m_tokens = 0;
        m_check  = 1'b0;
        m_over   = 1'b0;
    endtask

    // Buttons are treated as already held when reset lets go
    task automatic model_reset();
        model_new_game();
        m_pl = 1'b1;
        m_pr = 1'b1;
        m_pp = 1'b1;
    endtask

    task automatic model_step(input bit l, input bit r, input bit p);
        bit le = l && !m_pl;
        bit re = r && !m_pr;
        bit pe = p && !m_pp;
        int h;
        m_pl = l;
        m_pr = r;
        m_pp = p;
        if (m_check) begin
            m_check = 1'b0;
            if (has_win(m_player + 1)) begin
                m_winner = m_player + 1;
                m_over   = 1'b1;
            end else if (m_tokens == 42) begin
                m_winner = 3;
                m_over   = 1'b1;
            end else begin
                m_player = 1 - m_player;
            end
        end else if (m_over) begin
            if (pe) model_new_game();
        end else if (pe) begin
            h = 0;
            while (h < 6 && m_board[h][m_col] != 0) h++;
            if (h < 6) begin
                m_board[h][m_col] = m_player + 1;
                m_tokens++;
                m_check = 1'b1;
            end
        end else if (le && !re) begin
            m_col = (m_col + 6) % 7;
        end else if (re && !le) begin
            m_col = (m_col + 1) % 7;
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 7; c++) e.panel[r][c] = 2'(m_board[r][c]);
        end
        e.play   = 7'(1 << m_col);
        e.player = m_player[0];
        e.winner = 2'(m_winner);
        return e;
    endfunction

    task automatic cycle(input bit l, input bit r, input bit p);
        @(negedge clk);
        rst   = 1'b1;
        left  = l;
        right = r;
        put   = p;
        model_step(l, r, p);
        exp_q.push_back(model_view());
    endtask

    task automatic reset_cycles(input int n, input bit l, input bit r, input bit p);
        repeat (n) begin
            @(negedge clk);
            rst   = 1'b0;
            left  = l;
            right = r;
            put   = p;
            model_reset();
            exp_q.push_back(model_view());
        end
    endtask

    task automatic press(input bit l, input bit r, input bit p);
        cycle(l, r, p);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic goto_col(input int t);
        int guard = 0;
        while (m_col != t && guard < 8) begin
            press(1'b0, 1'b1, 1'b0);
            guard++;
        end
    endtask

    task automatic drop_in(input int t);
        goto_col(t);
        press(1'b0, 1'b0, 1'b1);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (panel !== mon_e.panel) begin
                n_fail++;
                $display("FAIL panel [%s] got %h want %h", phase, panel, mon_e.panel);
            end
            n_tests++;
            if (play !== mon_e.play) begin
                n_fail++;
                $display("FAIL play [%s] got %b want %b", phase, play, mon_e.play);
            end
            n_tests++;
            if (player !== mon_e.player) begin
                n_fail++;
                $display("FAIL player [%s] got %b want %b", phase, player, mon_e.player);
            end
            n_tests++;
            if (winner !== mon_e.winner) begin
                n_fail++;
                $display("FAIL winner [%s] got %b want %b", phase, winner, mon_e.winner);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog [%s] got timeout want finish", phase);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        put   = 1'b0;
        model_reset();

        phase = "reset";
        reset_cycles(2, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        phase = "wrap";
        repeat (3) press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);

        phase = "vertical_win";
        reset_cycles(1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drop_in((i % 2 == 0) ? 3 : 4);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);

        phase = "full_column";
        for (int i = 0; i < 7; i++) drop_in(2);
        press(1'b0, 1'b0, 1'b1);

        phase = "draw";
        reset_cycles(1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 42; i++) drop_in(draw_seq[i]);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);

        phase = "midgame_reset";
        drop_in(1);
        cycle(1'b0, 1'b0, 1'b1);
        reset_cycles(2, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);

        phase = "held_across_reset";
        cycle(1'b1, 1'b0, 1'b0);
        reset_cycles(1, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_cycles(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/connect4_game_ctrl.md
CONNECT4_GAME_CTRL -- requirements
Module: connect4_game_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: left  in  1  move-selector-left button level, already synchronised and debounced.
REQ-004 SHALL have ports: right  in  1  move-selector-right button level, already synchronised and debounced.
REQ-005 SHALL have ports: put  in  1  drop-token button level, already synchronised and debounced.
REQ-006 SHALL have ports: panel  out  [5:0][6:0][1:0]  board as [row][col]; row 0 = bottom; cell 00 empty, 01 player 0, 10 player 1; 11 never driven.
REQ-007 SHALL have ports: play  out  7  one-hot selected column, bit j = column j.
REQ-008 SHALL have ports: player  out  1  player to move (0 or 1).
REQ-009 SHALL have ports: winner  out  2  00 in progress, 01 player 0 won, 10 player 1 won, 11 draw.
REQ-010 SHALL have no parameters; board fixed at 6 rows x 7 columns.

Function
REQ-011 SHALL edge-detect left/right/put internally: event = input high now, registered copy low; one action per press regardless of hold length.
REQ-012 SHALL implement FSM states PLAY, CHECK, OVER; all outputs registered.
REQ-013 In PLAY, left event SHALL rotate play right by one (column j -> j-1), column 0 wrapping to column 6.
REQ-014 In PLAY, right event SHALL rotate play left by one (column j -> j+1), column 6 wrapping to column 0.
REQ-015 Simultaneous left and right events SHALL leave play unchanged.
REQ-016 A put event SHALL take priority over same-cycle left/right events; those left/right events are discarded.
REQ-017 In PLAY, a put event on a non-full column SHALL write code {player,~player} into the lowest empty row of the selected column at that clock edge and enter CHECK.
REQ-018 A put event on a full column (row 5 occupied) SHALL be ignored: no board, player or state change.
REQ-019 CHECK SHALL last exactly one cycle and ignore all events.
REQ-020 CHECK SHALL evaluate every horizontal, vertical and both diagonal 4-in-a-row (69 lines) for the current player's code.
REQ-021 On a win, CHECK SHALL set winner to the current player's code (01/10) and enter OVER; player unchanged.
REQ-022 With no win and a token count of 42, CHECK SHALL set winner = 11 and enter OVER.
REQ-023 Otherwise CHECK SHALL toggle player and return to PLAY.
REQ-024 Latency from put-event clock edge: panel updated at that edge, winner/player updated at the following edge.
REQ-025 SHALL keep a 6-bit token counter: incremented on each accepted drop, range 0..42, never wraps.
REQ-026 In OVER, left/right events SHALL be ignored and the board frozen.
REQ-027 A put event in OVER SHALL clear the board, zero the counter, set winner = 00, player = 0, play = 7'b0001000, and enter PLAY.

Reset
REQ-028 rst low SHALL asynchronously force: panel all 00, play = 7'b0001000, player = 0, winner = 00, counter 0, edge registers 0, state PLAY.
REQ-029 Reset asserted mid-game or during CHECK SHALL abandon the game with no partial write; the first post-reset put event behaves as a fresh game.
REQ-030 Buttons held high across reset release SHALL NOT generate an event until released and pressed again.

Verification
REQ-031 Reset: release rst, no buttons -> panel 0, play 0001000, player 0, winner 00.
REQ-032 Wrap: 3 left presses -> play 0000001; 1 more left -> 1000000; left+right pressed together -> unchanged.
REQ-033 Vertical win: alternate put in col 3 (P0) and col 4 (P1), 7 drops total -> panel[0..3][3] = 01, panel[0..2][4] = 10, winner 01 one cycle after the 7th drop, player 0.
REQ-034 Full column: 7 puts into col 2 with no win -> rows 0..5 filled (01/10 alternating), 7th put ignored, counter 6, player 0.
REQ-035 Draw: 42-move no-win sequence -> winner 11 after the last drop; next put -> board cleared, winner 00, player 0.
REQ-036 Reset mid-game: assert rst one cycle after a put event -> all outputs return to reset values; held put does not drop.
